// File: rtl/mips_regfile_param_if.sv
// Register-file access bundle: decode-side read/reserve, writeback-side write,
// and the file's read results, busy flags and ready status.
interface mips_regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read_reg_1;
  logic [ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              busy_1;
  logic              busy_2;
  logic              signal_reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              signal_reg_reserve;
  logic [ADDR_W-1:0] reserve_reg;
  logic              ready;

  // Datapath side: drives indices, write and reserve requests.
  modport master (
    output read_reg_1, read_reg_2, signal_reg_write, write_reg, write_data,
           signal_reg_reserve, reserve_reg,
    input  read_data_1, read_data_2, busy_1, busy_2, ready
  );

  // Register file side.
  modport slave (
    input  read_reg_1, read_reg_2, signal_reg_write, write_reg, write_data,
           signal_reg_reserve, reserve_reg,
    output read_data_1, read_data_2, busy_1, busy_2, ready
  );
endinterface

// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file: two combinational read ports, one
// synchronous write port, optional hardwired r0, optional write bypass,
// a per-register busy scoreboard and a post-reset clear sweep.
module mips_regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_regfile_param_if.slave    rf
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              rsv_ok;
  logic [DATA_W-1:0] rd1, rd2;
  logic              b1, b2;

  // True for the hardwired-zero index when that feature is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
    return ZERO_REG && (idx == '0);
  endfunction

  // True when a same-cycle write should be forwarded to a read of idx.
  function automatic logic bypass_hit(input logic               wr_en,
                                      input logic [ADDR_W-1:0] wr_idx,
                                      input logic [ADDR_W-1:0] idx);
    return BYPASS && wr_en && (wr_idx == idx);
  endfunction

  assign run    = (state_q == S_RUN);
  assign wr_ok  = run && rf.signal_reg_write   && !is_zero(rf.write_reg);
  assign rsv_ok = run && rf.signal_reg_reserve && !is_zero(rf.reserve_reg);

  // Sweep sequencer: advance the clear pointer, leave INIT after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      if (cnt_q == LAST_IDX) begin
        state_d = S_RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Scoreboard next state: a write retires the register, a reserve (applied last) wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[rf.write_reg]   = 1'b0;
    if (rsv_ok) busy_d[rf.reserve_reg] = 1'b1;
  end

  // Control state: FSM, sweep counter and busy vector, all cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage: zeroed one entry per edge during the sweep, written by writeback in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_ok) begin
        mem_q[rf.write_reg] <= rf.write_data;
      end
    end
  end

  // Read port 1: zero during the sweep and for r0, forwarded write when bypassing.
  always_comb begin
    rd1 = '0;
    b1  = 1'b0;
    if (run && !is_zero(rf.read_reg_1)) begin
      if (bypass_hit(wr_ok, rf.write_reg, rf.read_reg_1)) begin
        rd1 = rf.write_data;
      end else begin
        rd1 = mem_q[rf.read_reg_1];
        b1  = busy_q[rf.read_reg_1];
      end
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    rd2 = '0;
    b2  = 1'b0;
    if (run && !is_zero(rf.read_reg_2)) begin
      if (bypass_hit(wr_ok, rf.write_reg, rf.read_reg_2)) begin
        rd2 = rf.write_data;
      end else begin
        rd2 = mem_q[rf.read_reg_2];
        b2  = busy_q[rf.read_reg_2];
      end
    end
  end

  assign rf.read_data_1 = rd1;
  assign rf.read_data_2 = rd2;
  assign rf.busy_1      = b1;
  assign rf.busy_2      = b2;
  assign rf.ready       = run;

endmodule

// File: tb/tb_mips_regfile_param.sv
// Bench for mips_regfile_param: two instances (r0 hardwired + bypass, and
// plain r0 without bypass) driven with identical directed and random traffic
// and compared against an array-based reference model.
module tb_mips_regfile_param;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mips_regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  mips_regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  mips_regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
    .clk (clk),
    .rst (rst),
    .rf  (bus0.slave)
  );

  mips_regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .clk (clk),
    .rst (rst),
    .rf  (bus1.slave)
  );

  // Reference model: index 0 = (ZERO_REG=1, BYPASS=1), index 1 = (0, 0).
  logic [DW-1:0] m_mem  [2][N];
  bit            m_busy [2][N];
  bit            m_ready;
  int            m_swept;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_read(input int k, input int idx, input bit we, input int wr,
                                     input logic [DW-1:0] wd,
                                     output logic [DW-1:0] data, output logic bsy);
    bit zr = (k == 0);
    bit bp = (k == 0);
    data = '0;
    bsy  = 1'b0;
    if (!m_ready) return;
    if (zr && idx == 0) return;
    if (bp && we && wr == idx && !(zr && wr == 0)) begin
      data = wd;
      return;
    end
    data = m_mem[k][idx];
    bsy  = m_busy[k][idx];
  endfunction

  // One clock cycle: drive at the falling edge, check settled outputs, advance the model at the rising edge.
  task automatic step(input bit r, input bit we, input int wr, input logic [DW-1:0] wd,
                      input bit rs, input int rr, input int a1, input int a2);
    logic [DW-1:0] ed;
    logic          eb;
    @(negedge clk);
    rst = r;
    bus0.signal_reg_write   = we;  bus1.signal_reg_write   = we;
    bus0.write_reg          = AW'(wr); bus1.write_reg      = AW'(wr);
    bus0.write_data         = wd;  bus1.write_data         = wd;
    bus0.signal_reg_reserve = rs;  bus1.signal_reg_reserve = rs;
    bus0.reserve_reg        = AW'(rr); bus1.reserve_reg    = AW'(rr);
    bus0.read_reg_1         = AW'(a1); bus1.read_reg_1     = AW'(a1);
    bus0.read_reg_2         = AW'(a2); bus1.read_reg_2     = AW'(a2);
    #1;
    chk("d0 ready", {31'd0, bus0.ready}, {31'd0, m_ready});
    chk("d1 ready", {31'd0, bus1.ready}, {31'd0, m_ready});
    model_read(0, a1, we, wr, wd, ed, eb);
    chk($sformatf("d0 rd1 r%0d", a1), bus0.read_data_1, ed);
    chk($sformatf("d0 busy1 r%0d", a1), {31'd0, bus0.busy_1}, {31'd0, eb});
    model_read(0, a2, we, wr, wd, ed, eb);
    chk($sformatf("d0 rd2 r%0d", a2), bus0.read_data_2, ed);
    chk($sformatf("d0 busy2 r%0d", a2), {31'd0, bus0.busy_2}, {31'd0, eb});
    model_read(1, a1, we, wr, wd, ed, eb);
    chk($sformatf("d1 rd1 r%0d", a1), bus1.read_data_1, ed);
    chk($sformatf("d1 busy1 r%0d", a1), {31'd0, bus1.busy_1}, {31'd0, eb});
    model_read(1, a2, we, wr, wd, ed, eb);
    chk($sformatf("d1 rd2 r%0d", a2), bus1.read_data_2, ed);
    chk($sformatf("d1 busy2 r%0d", a2), {31'd0, bus1.busy_2}, {31'd0, eb});
    @(posedge clk);
    if (r) begin
      m_ready = 1'b0;
      m_swept = 0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) m_busy[k][i] = 1'b0;
    end else if (!m_ready) begin
      for (int k = 0; k < 2; k++) m_mem[k][m_swept] = '0;
      m_swept++;
      if (m_swept == N) m_ready = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit zr = (k == 0);
        if (we && !(zr && wr == 0)) begin
          m_mem[k][wr]  = wd;
          m_busy[k][wr] = 1'b0;
        end
        if (rs && !(zr && rr == 0)) m_busy[k][rr] = 1'b1;
      end
    end
  endtask

  task automatic rnd_step();
    step(1'b0, ($urandom_range(0, 2) != 0), $urandom_range(0, N-1), $urandom,
         ($urandom_range(0, 3) == 0), $urandom_range(0, N-1),
         $urandom_range(0, N-1), $urandom_range(0, N-1));
  endtask

  initial begin
    m_ready = 1'b0;
    m_swept = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        m_mem[k][i]  = 'x;
        m_busy[k][i] = 1'b0;
      end
    bus0.signal_reg_write = 1'b0; bus1.signal_reg_write = 1'b0;
    bus0.write_reg = '0;          bus1.write_reg = '0;
    bus0.write_data = '0;         bus1.write_data = '0;
    bus0.signal_reg_reserve = 1'b0; bus1.signal_reg_reserve = 1'b0;
    bus0.reserve_reg = '0;        bus1.reserve_reg = '0;
    bus0.read_reg_1 = '0;         bus1.read_reg_1 = '0;
    bus0.read_reg_2 = '0;         bus1.read_reg_2 = '0;
    @(posedge clk);

    // Reset state, then a sweep interrupted by reset at cycle 20.
    step(1'b1, 0, 0, '0, 0, 0, 0, 5);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) step(1'b0, 1, 3, 32'h1, 1, 3, 3, 3);
      else         rnd_step();
    end
    step(1'b1, 0, 0, '0, 0, 0, 3, 9);

    // Full sweep with traffic that must be ignored.
    for (int c = 0; c < N; c++) begin
      if (c == 10) step(1'b0, 1, 3, 32'h1, 1, 3, 3, 3);
      else         rnd_step();
    end

    // r3 untouched by INIT traffic.
    step(1'b0, 0, 0, '0, 0, 0, 3, 0);

    // Write/readback with and without bypass.
    step(1'b0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    step(1'b0, 0, 0, '0, 0, 0, 5, 3);

    // Zero register write and reserve.
    step(1'b0, 1, 0, 32'h12345678, 1, 0, 0, 0);
    step(1'b0, 0, 0, '0, 0, 0, 0, 5);

    // Scoreboard on r7.
    step(1'b0, 0, 0, '0, 1, 7, 7, 7);
    step(1'b0, 0, 0, '0, 0, 0, 7, 0);
    step(1'b0, 1, 7, 32'h55, 0, 0, 7, 7);
    step(1'b0, 0, 0, '0, 0, 0, 7, 7);
    step(1'b0, 1, 7, 32'hAA, 1, 7, 7, 7);
    step(1'b0, 0, 0, '0, 0, 0, 7, 7);

    // Randomized traffic in RUN.
    for (int c = 0; c < 400; c++) rnd_step();

    // Reset from RUN after writing r9, then a full sweep and a scan of every entry.
    step(1'b0, 1, 9, 32'h99, 1, 12, 9, 12);
    step(1'b0, 0, 0, '0, 0, 0, 9, 12);
    step(1'b1, 0, 0, '0, 0, 0, 9, 12);
    for (int c = 0; c < N; c++) rnd_step();
    for (int i = 0; i < N; i++) step(1'b0, 0, 0, '0, 0, 0, i, N-1-i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_regfile_param.md
# mips_regfile_param

Parametrised MIPS general-purpose register file with two combinational read ports and one synchronous write port. It adds four things: a configurable data width and depth, a hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard for in-flight results. A post-reset clear sequencer zeroes every entry, one per cycle, before the file accepts traffic. It sits between decode (read ports, reserve) and writeback (write port) in the core datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores write/reserve
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- read_reg_1  in  ADDR_W  read port 1 index
- read_reg_2  in  ADDR_W  read port 2 index
- read_data_1  out  DATA_W  read port 1 data
- read_data_2  out  DATA_W  read port 2 data
- busy_1  out  1  register read_reg_1 has a pending result
- busy_2  out  1  register read_reg_2 has a pending result
- signal_reg_write  in  1  write enable
- write_reg  in  ADDR_W  write index
- write_data  in  DATA_W  write data
- signal_reg_reserve  in  1  mark reserve_reg busy (producer issued)
- reserve_reg  in  ADDR_W  index to reserve
- ready  out  1  clear sweep done; file accepts writes and reserves

## Operation
- Storage: DEPTH x DATA_W array, plus a DEPTH-bit busy vector.
- FSM states:
  - INIT: clear sweep; each edge writes 0 to entry[cnt], then cnt++.
  - RUN: normal operation.
- Transitions:
  - rst -> INIT with cnt=0, regardless of current state.
  - INIT -> RUN on the edge that clears entry DEPTH-1.
  - RUN holds until rst.
- cnt is ADDR_W bits; it must not wrap back into INIT.
- rst clears the whole busy vector in one cycle.
- In INIT:
  - signal_reg_write and signal_reg_reserve are ignored.
  - read_data_x = 0 and busy_x = 0.
- Write (RUN): on the edge where signal_reg_write=1 and the target is not the zero register:
  - entry[write_reg] <= write_data
  - busy[write_reg] <= 0
- Reserve (RUN): on the edge where signal_reg_reserve=1 and the target is not the zero register, busy[reserve_reg] <= 1.
- Write and reserve to the same index on the same edge: data is written and busy ends at 1 (reserve wins).
- Zero register (ZERO_REG=1): index 0 always reads 0 with busy 0; writes and reserves to index 0 are dropped.
- Read (RUN), combinational:
  - read_data_x = entry[read_reg_x], except 0 for index 0 under ZERO_REG.
  - busy_x = busy[read_reg_x].
- Bypass (BYPASS=1, RUN): if signal_reg_write=1, write_reg == read_reg_x, and the index is not the zero register, then read_data_x = write_data and busy_x = 0. This applies to both ports independently.
- With BYPASS=0, reads return the pre-edge contents; the written value is visible the cycle after the edge.

## Timing
- Reset values: ready=0, read_data_1/2=0, busy_1/2=0, cnt=0, state INIT.
- Clear latency: after rst deasserts, DEPTH rising edges clear entries 0..DEPTH-1. ready goes high after the DEPTH-th edge (32 edges for ADDR_W=5).
- Write latency: 1 edge to storage; 0 cycles to a read port with bypass.
- Reserve latency: busy_x goes high in the cycle after the reserve edge.
- A reserve and a read of the same index in the same cycle returns busy_x=0 until the edge (no forwarding of reserve).
- rst asserted mid-sweep or in RUN: takes effect on that edge, the sweep restarts from 0, and ready drops the following cycle.
- Read data and busy outputs are purely combinational from state and inputs; there are no internal read-path registers.

## Test plan
- Clear sweep: preload X, pulse rst 1 cycle, DEPTH=32 -> ready=0 for 32 edges, then 1; every index reads 0 and busy=0.
- Write/readback: RUN, write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF. With BYPASS=1, read_data_1 = 0xDEADBEEF in the write cycle itself; with BYPASS=0, it shows the old value (0).
- Zero register: write 0x12345678 to r0 and reserve r0 -> r0 reads 0, busy=0 (ZERO_REG=1). With ZERO_REG=0, r0 reads 0x12345678.
- Scoreboard: reserve r7 -> busy=1 on r7 next cycle. Write r7=0x55 -> busy=0, data 0x55. Write and reserve r7=0xAA on the same edge -> data 0xAA, busy=1.
- Ignored traffic during INIT: write r3=0x1 and reserve r3 at sweep cycle 10 -> after ready, r3 reads 0, busy=0.
- Reset mid-operation: rst asserted at sweep cycle 20 and again in RUN after writing r9=0x99 -> ready low for 32 edges, r9=0, all busy=0.
